// File: rtl/bus_arbiter3_if.sv
// Shared-bus bundle for bus_arbiter3: three producer request lanes, one-hot steering
// select, and the registered valid/ready output stage.
interface bus_arbiter3_if #(
    parameter int WIDTH = 8
) ();
    logic [2:0]         req_valid;
    logic [2:0]         req_last;
    logic [3*WIDTH-1:0] req_data;
    logic [2:0]         req_ready;
    logic [2:0]         sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    // Arbiter side.
    modport slave (
        input  req_valid, req_last, req_data, out_ready,
        output req_ready, sel, out_data, out_last, out_valid, busy
    );

    // Producer/consumer side.
    modport master (
        output req_valid, req_last, req_data, out_ready,
        input  req_ready, sel, out_data, out_last, out_valid, busy
    );
endinterface

// File: rtl/bus_arbiter3.sv
// Round-robin, burst-granular arbiter for three producers sharing one bus.
// The winner's beats pass through a one-entry registered valid/ready stage.
module bus_arbiter3 #(
    parameter int WIDTH = 8
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    bus_arbiter3_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t           state;
    logic [2:0]       sel_q;
    logic [1:0]       lg;
    logic [WIDTH-1:0] data_p1;
    logic             last_p1;
    logic             vld_p1;

    logic             slot_free;
    logic [2:0]       ready;
    logic             xfer;
    logic             glast;
    logic [1:0]       gidx;
    logic [WIDTH-1:0] gdata;

    // Search starts just after the last granted producer and wraps.
    function automatic logic [2:0] rr_pick(input logic [2:0] valid, input logic [1:0] last);
        logic [2:0] pick;
        case (last)
            2'd0:    pick = valid[1] ? 3'b010 : valid[2] ? 3'b100 : valid[0] ? 3'b001 : 3'b000;
            2'd1:    pick = valid[2] ? 3'b100 : valid[0] ? 3'b001 : valid[1] ? 3'b010 : 3'b000;
            default: pick = valid[0] ? 3'b001 : valid[1] ? 3'b010 : valid[2] ? 3'b100 : 3'b000;
        endcase
        return pick;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
        logic [1:0] idx;
        case (oh)
            3'b010:  idx = 2'd1;
            3'b100:  idx = 2'd2;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    always_comb begin
        slot_free = !vld_p1 || bus.out_ready;
        ready     = (state == BURST) ? (sel_q & {3{slot_free}}) : 3'b000;
        xfer      = |(ready & bus.req_valid);
        glast     = |(sel_q & bus.req_last);
        gidx      = onehot_idx(sel_q);
        case (gidx)
            2'd0:    gdata = bus.req_data[3*WIDTH-1:2*WIDTH];
            2'd1:    gdata = bus.req_data[2*WIDTH-1:WIDTH];
            default: gdata = bus.req_data[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            sel_q   <= 3'b000;
            lg      <= 2'd2;
            data_p1 <= '0;
            last_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            // p0 -> p1: output register, load wins over drain
            if (xfer) begin
                data_p1 <= gdata;
                last_p1 <= glast;
                vld_p1  <= 1'b1;
            end else if (vld_p1 && bus.out_ready) begin
                vld_p1  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        sel_q <= rr_pick(bus.req_valid, lg);
                        state <= BURST;
                    end
                end
                BURST: begin
                    // Grant is held until the last beat; no timeout.
                    if (xfer && glast) begin
                        lg    <= gidx;
                        sel_q <= 3'b000;
                        state <= IDLE;
                    end
                end
                default: begin
                    sel_q <= 3'b000;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.sel       = sel_q;
    assign bus.out_data  = data_p1;
    assign bus.out_last  = last_p1;
    assign bus.out_valid = vld_p1;
    assign bus.busy      = (state == BURST);
endmodule

// File: doc/bus_arbiter3.md
# bus_arbiter3

Sequential counterpart to the combinational 3-way bus mux and demux blocks. Three producers compete for one shared bus. This block arbitrates round-robin at burst granularity and drives the one-hot `sel[2:0]` that steers the shared bus. It presents the granted producer's beats through a registered valid/ready output stage with full backpressure. It sits between the bytebeat sample generators and the shared output bus.

## Interface
- `WIDTH`, default 8: data width per producer and of the output bus.
- `wb_clk_i`  in  1  sole clock; all state updates on rising edge.
- `wb_rst_i`  in  1  asynchronous, active-high reset.
- `req_valid`  in  3  per-producer beat valid; bit i belongs to producer i.
- `req_last`  in  3  per-producer end-of-burst flag, qualified by `req_valid[i]`.
- `req_data`  in  3*WIDTH  packed `{p0, p1, p2}`: producer 0 = [3W-1:2W], producer 1 = [2W-1:W], producer 2 = [W-1:0].
- `req_ready`  out  3  per-producer ready; at most one bit high.
- `sel`  out  3  registered one-hot grant; bit i = producer i; 000 when idle.
- `out_data`  out  WIDTH  registered output beat.
- `out_last`  out  1  registered end-of-burst flag for `out_data`.
- `out_valid`  out  1  output beat valid.
- `out_ready`  in  1  downstream accept.
- `busy`  out  1  high in BURST state.

## Operation
- Two-state FSM: IDLE, BURST.
  - The state register, `sel`, a 2-bit last-grant pointer `lg`, and a one-entry output register hold all state.
- **IDLE**
  - `req_ready` = 000 and `sel` = 000.
  - If any `req_valid` bit is high, pick the first valid producer searching from (`lg`+1) mod 3 upward, wrapping.
  - Next edge: `sel` gets that producer's one-hot bit and the state goes to BURST.
  - If no `req_valid` bit is high, stay in IDLE.
- **BURST**, granted producer g
  - `req_ready[g]` = `!out_valid || out_ready`. All other `req_ready` bits are 0.
  - A transfer occurs when `req_valid[g] && req_ready[g]`. On that edge:
    - `out_data` gets slice g of `req_data`.
    - `out_last` gets `req_last[g]`.
    - `out_valid` is set to 1.
  - A transfer with `req_last[g]` = 1 ends the burst on the same edge: state goes to IDLE, `sel` goes to 000, and `lg` gets g.
  - Otherwise the state stays BURST and the grant is held, even if `req_valid[g]` drops. There is no timeout.
- **Output register**
  - `out_valid` clears on `out_valid && out_ready` unless a new transfer loads it on the same edge.
  - While `out_valid && !out_ready`, `out_data` and `out_last` are held stable.
- **Simultaneous events**
  - Drain and load on the same edge: the new beat replaces the old one and `out_valid` stays 1. Full throughput is 1 beat/cycle.
  - A `req_valid` from a non-granted producer during BURST is ignored until after IDLE re-arbitration.
- **Reset**
  - Asynchronous, effective immediately, including mid-burst. Any pending output beat is discarded.
  - Reset values: state IDLE, `sel` 000, `req_ready` 000, `out_valid` 0, `out_data` 0, `out_last` 0, `busy` 0, `lg` 2 (so producer 0 has first priority).

## Timing
- Arbitration costs one cycle: a valid request seen in IDLE at edge N gives a grant (`sel`, `busy`) after edge N.
- First beat transfers at edge N+1 if downstream is not stalled. `out_valid` is high after edge N+1, so request-to-output latency is 2 cycles.
- Subsequent beats in a burst: 1 cycle latency, 1 beat/cycle.
- Gap between bursts: end of burst at edge M gives IDLE after M. The next grant appears after M+1 and its first beat transfers at M+2, i.e. one bubble cycle on the output.
- `req_ready` is combinational from `out_valid`, `out_ready`, state and `sel`. It has no combinational path from `req_valid`.
- `sel` and all `out_*` signals are registered, glitch-free and one-hot-or-zero.

## Test plan
- Reset then single request: p1 sends 0x2B with last=1. Expected:
  - `sel`=010 one cycle after the request.
  - `out_data`=0x2B, `out_last`=1, `out_valid`=1 two cycles after the request.
  - `sel`=000 afterwards and `lg`=1.
- Round-robin: all three requesters hold valid with single-beat bursts 0x2A, 0x2B, 0x2C from reset. Expected output order is p0, p1, p2, p0, with one bubble between beats.
- Burst lock: p2 sends a 4-beat burst 0x10..0x13 (last on 0x13) while p0 is valid throughout. Expected:
  - `sel` stays 100 for all 4 beats.
  - p0 is granted only after 0x13 transfers.
- Backpressure: `out_ready`=0 for 5 cycles mid-burst. Expected:
  - `out_data` stable, `req_ready` = 000 while `out_valid` is set.
  - No beat is lost or duplicated when `out_ready` returns to 1.
- Grant hold: the granted producer drops `req_valid` for 3 cycles mid-burst. Expected: `sel` is unchanged and `busy`=1 throughout.
- Async reset mid-burst with `out_valid`=1. Expected:
  - All outputs reach their reset values before the next clock edge.
  - The next arbitration grants p0 first.
